// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter for the shared data bus
// One outstanding transaction; slave wait states bounded by a timeout that forces an error completion.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_be_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_err_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic          owner_q;
  logic          last_grant_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          timeout;
  logic          done;
  logic [31:0]   done_rdata;
  logic          done_err;
  logic          s_req_q;
  logic [31:0]   s_addr_q;
  logic [31:0]   s_wdata_q;
  logic [3:0]    s_be_q;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic [31:0]   m0_rdata_q, m1_rdata_q;
  logic          m0_err_q, m1_err_q;

  // On a tie the master that did not win last time gets the bus.
  assign m0_gnt_o = (state_q == IDLE) && m0_req_i && (!m1_req_i || last_grant_q);
  assign m1_gnt_o = (state_q == IDLE) && m1_req_i && (!m0_req_i || !last_grant_q);

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    timeout    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    done       = s_ready_i || timeout;
    // A ready slave beats a simultaneous timeout.
    done_rdata = s_ready_i ? s_rdata_i : 32'h0;
    done_err   = s_ready_i ? s_err_i : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      s_req_q      <= 1'b0;
      s_addr_q     <= 32'h0;
      s_wdata_q    <= 32'h0;
      s_be_q       <= 4'h0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= 32'h0;
      m1_rdata_q   <= 32'h0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_gnt_o || m1_gnt_o) begin
            s_addr_q     <= m1_gnt_o ? m1_addr_i  : m0_addr_i;
            s_wdata_q    <= m1_gnt_o ? m1_wdata_i : m0_wdata_i;
            s_be_q       <= m1_gnt_o ? m1_be_i    : m0_be_i;
            owner_q      <= m1_gnt_o;
            last_grant_q <= m1_gnt_o;
            cnt_q        <= '0;
            s_req_q      <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            if (owner_q) begin
              m1_rvalid_q <= 1'b1;
              m1_rdata_q  <= done_rdata;
              m1_err_q    <= done_err;
            end else begin
              m0_rvalid_q <= 1'b1;
              m0_rdata_q  <= done_rdata;
              m0_err_q    <= done_err;
            end
            s_req_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_req_o     = s_req_q;
  assign s_addr_o    = s_addr_q;
  assign s_wdata_o   = s_wdata_q;
  assign s_be_o      = s_be_q;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m0_err_o    = m0_err_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign m1_err_o    = m1_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_ready, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  int tests = 0;
  int fails = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata), .s_err_i(s_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_be = 0; m1_be = 0; s_ready = 0; s_rdata = 0; s_err = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_s_req", 32'(s_req), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_be", 32'(s_be), 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_m0_err", 32'(m0_err), 32'h0);

    // Single M0 write, minimum latency
    m0_req = 1; m0_addr = 32'h10; m0_be = 4'hF; m0_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_m0_gnt", 32'(m0_gnt), 32'h1);
    chk("wr_m1_gnt", 32'(m1_gnt), 32'h0);
    tick();
    m0_req = 0; s_ready = 1; s_rdata = 32'h0;
    #1;
    chk("wr_s_req", 32'(s_req), 32'h1);
    chk("wr_s_addr", s_addr, 32'h10);
    chk("wr_s_be", 32'(s_be), 32'hF);
    chk("wr_s_wdata", s_wdata, 32'hDEADBEEF);
    chk("wr_busy_gnt", 32'(m0_gnt), 32'h0);
    tick();
    s_ready = 0;
    #1;
    chk("wr_m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("wr_m0_err", 32'(m0_err), 32'h0);
    chk("wr_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("wr_s_req_low", 32'(s_req), 32'h0);

    // Round-robin under contention after reset
    reset = 1; tick(); reset = 0;
    m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200; m0_be = 4'h0; m1_be = 4'h0;
    s_ready = 1; s_rdata = 32'hCAFE0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_m0_gnt_%0d", i), 32'(m0_gnt), 32'((i % 4) == 0));
      chk($sformatf("rr_m1_gnt_%0d", i), 32'(m1_gnt), 32'((i % 4) == 2));
      chk($sformatf("rr_m0_rvalid_%0d", i), 32'(m0_rvalid), 32'(i == 2 || i == 6));
      chk($sformatf("rr_m1_rvalid_%0d", i), 32'(m1_rvalid), 32'(i == 4));
      if ((i % 4) == 1) chk($sformatf("rr_s_addr_%0d", i), s_addr, 32'h100);
      if ((i % 4) == 3) chk($sformatf("rr_s_addr_%0d", i), s_addr, 32'h200);
      tick();
    end
    m0_req = 0; m1_req = 0; s_ready = 0;
    #1;
    chk("rr_m1_rvalid_end", 32'(m1_rvalid), 32'h1);
    chk("rr_m1_rdata", m1_rdata, 32'hCAFE0000);

    // M1 read with no slave response -> timeout error
    m1_req = 1; m1_addr = 32'h300; s_rdata = 32'h5555AAAA;
    #1;
    chk("to_m1_gnt", 32'(m1_gnt), 32'h1);
    tick();
    m1_req = 0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk($sformatf("to_wait_rvalid_%0d", k), 32'(m1_rvalid), 32'h0);
      chk($sformatf("to_wait_s_req_%0d", k), 32'(s_req), 32'h1);
      tick();
    end
    #1;
    chk("to_m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("to_m1_err", 32'(m1_err), 32'h1);
    chk("to_m1_rdata", m1_rdata, 32'h0);
    chk("to_m0_rvalid", 32'(m0_rvalid), 32'h0);

    // M0 read with bridge error
    m0_req = 1; m0_addr = 32'h20; m0_be = 4'h0;
    #1;
    chk("se_m0_gnt", 32'(m0_gnt), 32'h1);
    tick();
    m0_req = 0; s_ready = 1; s_err = 1; s_rdata = 32'h1234;
    tick();
    s_ready = 0; s_err = 0;
    #1;
    chk("se_m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("se_m0_err", 32'(m0_err), 32'h1);
    chk("se_m0_rdata", m0_rdata, 32'h1234);
    chk("se_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("se_m1_rdata_hold", m1_rdata, 32'h0);
    tick();
    chk("se_m0_rvalid_pulse", 32'(m0_rvalid), 32'h0);
    chk("se_m0_rdata_hold", m0_rdata, 32'h1234);

    // s_ready arriving exactly on the timeout cycle
    m1_req = 1; m1_addr = 32'h400;
    #1;
    chk("tr_m1_gnt", 32'(m1_gnt), 32'h1);
    tick();
    m1_req = 0;
    for (int k = 1; k < 16; k++) begin
      #1;
      chk($sformatf("tr_wait_rvalid_%0d", k), 32'(m1_rvalid), 32'h0);
      tick();
    end
    s_ready = 1; s_rdata = 32'hA5A5A5A5;
    tick();
    s_ready = 0;
    #1;
    chk("tr_m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("tr_m1_err", 32'(m1_err), 32'h0);
    chk("tr_m1_rdata", m1_rdata, 32'hA5A5A5A5);

    // Reset two cycles into BUSY abandons the transaction
    m0_req = 1; m0_addr = 32'h500;
    #1;
    chk("rb_m0_gnt", 32'(m0_gnt), 32'h1);
    tick();
    m0_req = 0;
    tick();
    reset = 1; s_ready = 1; s_rdata = 32'h77777777;
    tick();
    reset = 0; s_ready = 0;
    #1;
    chk("rb_s_req", 32'(s_req), 32'h0);
    chk("rb_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rb_s_addr", s_addr, 32'h0);
    chk("rb_m0_rdata", m0_rdata, 32'h0);
    m0_req = 1; m1_req = 1;
    #1;
    chk("rb_tie_m0_gnt", 32'(m0_gnt), 32'h1);
    chk("rb_tie_m1_gnt", 32'(m1_gnt), 32'h0);
    tick();
    m0_req = 0; m1_req = 0; s_ready = 1; s_rdata = 32'h9;
    tick();
    s_ready = 0;
    #1;
    chk("rb_after_m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("rb_after_m0_rdata", m0_rdata, 32'h9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
